route_lookup_arbiter: RTL and testbench

Shares one per-node routing table among the router's input ports.
- Each input port presents a destination node ID. The block arbitrates among the requesting ports, drives the table address, captures the returned direction and hands it back with a one-hot acknowledge.
- Sits between the input-port header decoders and the node's routing_table instance inside the router.

---
 rtl/route_lookup_arbiter_pkg.sv | 19 +
 rtl/route_lookup_arbiter_rr_arbiter.sv | 33 +++
 rtl/route_lookup_arbiter.sv | 93 +++++++++
 tb/tb_route_lookup_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/route_lookup_arbiter_pkg.sv
// Shared types for the routing-table lookup arbiter: FSM state encoding and the
// node-ID/direction widths normally supplied by constants_2D.v.
`ifndef SIZE
`define SIZE 4
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

package route_lookup_arbiter_pkg;

  // Same encoding as the other router FSMs so debug views line up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } lookup_state_t;

endpackage

// File: rtl/route_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr (mod N) and
// returns the first set bit as one-hot and index. ptr tied to 0 gives a priority encoder.
module route_lookup_arbiter_rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [PW:0] idx;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single subtraction wraps the index.
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!grant_any && req[idx[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
    if (grant_any) grant = N'(1) << grant_idx;
  end

endmodule

// File: rtl/route_lookup_arbiter.sv
// Arbitrates input-port access to the shared routing table: IDLE -> ADDR -> DATA.
// Define ROUTE_ARB_RR_EN for round-robin arbitration; otherwise lowest port index wins.
module route_lookup_arbiter
  import route_lookup_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [NUM_PORTS*`SIZE-1:0]   dest,
  output logic [`SIZE-1:0]             table_addr,
  input  logic [`BITS_DIR-1:0]         table_data,
  output logic [NUM_PORTS-1:0]         ack,
  output logic [`BITS_DIR-1:0]         resp_dir,
  output logic                         busy,
  output logic [CNT_W-1:0]             lookup_count,
  output lookup_state_t                state_dbg
);

  localparam int PW = $clog2(NUM_PORTS);

  lookup_state_t          state, state_nxt;
  logic [NUM_PORTS-1:0]   grant, grant_q;
  logic [PW-1:0]          grant_idx, arb_ptr;
  logic                   grant_any;

  route_lookup_arbiter_rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
    .req       (req),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef ROUTE_ARB_RR_EN
  logic [PW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == IDLE && grant_any) begin
      rr_ptr <= (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + PW'(1);
    end
  end

  assign arb_ptr = rr_ptr;
`else
  assign arb_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ADDR;
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ack is registered out of DATA, so it lands in the IDLE cycle that may also grant again.
  always_ff @(posedge clk) begin
    if (reset) begin
      table_addr   <= '0;
      grant_q      <= '0;
      ack          <= '0;
      resp_dir     <= '0;
      lookup_count <= '0;
    end else begin
      ack <= '0;
      if (state == IDLE && grant_any) begin
        table_addr <= dest[int'(grant_idx)*`SIZE +: `SIZE];
        grant_q    <= grant;
      end
      if (state == DATA) begin
        resp_dir     <= table_data;
        ack          <= grant_q;
        lookup_count <= lookup_count + CNT_W'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_route_lookup_arbiter.sv
// Bench for route_lookup_arbiter with an XY routing table for node 5 of a 4x4 mesh attached.
module tb_route_lookup_arbiter;
  import route_lookup_arbiter_pkg::*;

  localparam int N       = 5;
  localparam int CNT_W   = 4;
  localparam int SZ      = `SIZE;
  localparam int BD      = `BITS_DIR;
  localparam int W       = N + BD;
  localparam int NODE_ID = 5;
  localparam int MESH_X  = 4;
  localparam int DIR_N = 0, DIR_E = 1, DIR_S = 2, DIR_W = 3, DIR_LOCAL = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*SZ-1:0]   dest;
  logic [SZ-1:0]     table_addr;
  logic [BD-1:0]     table_data;
  logic [N-1:0]      ack;
  logic [BD-1:0]     resp_dir;
  logic              busy;
  logic [CNT_W-1:0]  lookup_count;
  lookup_state_t     state_dbg;

  logic [W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  bit mon_en     = 1'b0;

  always #5 clk = ~clk;

  route_lookup_arbiter #(.NUM_PORTS(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .dest         (dest),
    .table_addr   (table_addr),
    .table_data   (table_data),
    .ack          (ack),
    .resp_dir     (resp_dir),
    .busy         (busy),
    .lookup_count (lookup_count),
    .state_dbg    (state_dbg)
  );

  // XY dimension-order routing: resolve X first, then Y.
  function automatic logic [BD-1:0] route_of(int d);
    int cx, cy, dx, dy;
    cx = NODE_ID % MESH_X;
    cy = NODE_ID / MESH_X;
    dx = d % MESH_X;
    dy = d / MESH_X;
    if (dx > cx) return BD'(DIR_E);
    if (dx < cx) return BD'(DIR_W);
    if (dy > cy) return BD'(DIR_S);
    if (dy < cy) return BD'(DIR_N);
    return BD'(DIR_LOCAL);
  endfunction

  assign table_data = route_of(int'(table_addr));

  function automatic int pick(logic [N-1:0] r, int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: lookup in flight for two cycles after each grant decision.
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            m_count = 0;
  int            m_g;
  logic [SZ-1:0] m_addr  = '0;
  logic [BD-1:0] m_resp  = '0;
  bit            m_ack_due = 1'b0;

  always @(posedge clk) begin
    m_ack_due = 1'b0;
    if (reset) begin
      m_phase = 0;
      m_ptr   = 0;
      m_count = 0;
      m_addr  = '0;
      m_resp  = '0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      m_g = pick(req, m_ptr);
      if (m_g >= 0) begin
        m_addr = dest[m_g*SZ +: SZ];
        exp_q.push_back({N'(1) << m_g, route_of(int'(m_addr))});
`ifdef ROUTE_ARB_RR_EN
        m_ptr = (m_g + 1) % N;
`endif
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase   = 0;
      m_count   = (m_count + 1) % (1 << CNT_W);
      m_resp    = route_of(int'(m_addr));
      m_ack_due = 1'b1;
    end
  end

  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("state_idle", 32'(state_dbg == IDLE), 32'(m_phase == 0));
      check("table_addr", 32'(table_addr), 32'(m_addr));
      check("lookup_count", 32'(lookup_count), 32'(m_count));
      check("resp_dir", 32'(resp_dir), 32'(m_resp));
      check("ack_timing", 32'(ack != '0), 32'(m_ack_due));
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'(ack), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_resp", 32'({ack, resp_dir}), 32'(mon_e));
        end
      end else if (m_ack_due && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
      end
    end
  end

  task automatic wait_ack(input int p, output int lat);
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (ack[p]) break;
    end
    if (!ack[p]) check("ack_timeout", 32'(ack), 32'(1 << p));
  endtask

  task automatic lookup(input int p, input int d);
    int lat;
    dest[p*SZ +: SZ] = SZ'(d);
    req[p] = 1'b1;
    wait_ack(p, lat);
    req[p] = 1'b0;
    check("latency", 32'(lat), 32'(3));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    req   = '0;
    dest  = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Single lookups covering every direction.
    lookup(0, 0);
    lookup(0, 5);
    lookup(0, 1);
    lookup(0, 9);
    lookup(1, 2);

    // All ports contending continuously.
    for (int p = 0; p < N; p++) dest[p*SZ +: SZ] = SZ'(p * 3);
    req = '1;
    repeat (20) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Two ports contending, then the favoured one withdraws.
    req = N'(5'b00110);
    repeat (12) @(negedge clk);
    req[1] = 1'b0;
    repeat (8) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Reset while the grant sits in ADDR.
    dest[2*SZ +: SZ] = SZ'(7);
    req[2] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ack(2, lat);
    req[2] = 1'b0;
    check("latency_after_reset", 32'(lat), 32'(3));
    repeat (4) @(negedge clk);

    // Request withdrawn during ADDR still gets exactly one ack.
    dest[3*SZ +: SZ] = SZ'(11);
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    repeat (8) @(negedge clk);

    // Randomised traffic with holds, withdrawals and one reset pulse.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            dest[i*SZ +: SZ] = SZ'($urandom_range(0, (1 << SZ) - 1));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end
      end
      reset = (c == 200);
      @(negedge clk);
    end
    reset = 1'b0;
    req   = '0;
    repeat (6) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
